// File: rtl/seq_comparator_nbit.sv
// Sequential MSB-first magnitude comparator: scans K bits per clock and stops
// at the first differing digit, with start/done handshake and signed mode.
module seq_comparator_nbit #(
  parameter int N = 16,
  parameter int K = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         GT,
  output logic         EQ,
  output logic         LT
);

  localparam int D = N / K;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [N-1:0] MSB_MASK = N'(1'b1) << (N - 1);

  generate
    if ((K < 1) || (N < K) || ((N % K) != 0)) begin : g_bad_params
      $error("seq_comparator_nbit: N must be a non-zero multiple of K");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic [CW-1:0]   cnt_r;
  logic            gt_r;
  logic            eq_r;
  logic            lt_r;
  logic            busy_r;
  logic            done_r;
  logic            busy_s;
  logic            done_s;
  logic [K-1:0]    digit_a_s;
  logic [K-1:0]    digit_b_s;
  logic            digit_ne_s;
  logic            digit_gt_s;
  logic            last_s;

  // Operands shift left each scanned digit, so the current digit is always on top.
  assign digit_a_s  = a_r[N-1 -: K];
  assign digit_b_s  = b_r[N-1 -: K];
  assign digit_ne_s = (digit_a_s != digit_b_s);
  assign digit_gt_s = (digit_a_s > digit_b_s);
  assign last_s     = (cnt_r == LAST);

  // State register plus registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (digit_ne_s || last_s) begin
          state_s = DONE;
        end else begin
          state_s = SCAN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so busy/done leave a flop
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      IDLE: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      SCAN: begin
        busy_s = 1'b1;
        done_s = 1'b0;
      end
      DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Operand capture, digit scan and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= {N{1'b0}};
      b_r   <= {N{1'b0}};
      cnt_r <= {CW{1'b0}};
      gt_r  <= 1'b0;
      eq_r  <= 1'b0;
      lt_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            // Flipping both sign bits turns a signed compare into an unsigned one.
            a_r   <= A ^ (signed_mode ? MSB_MASK : {N{1'b0}});
            b_r   <= B ^ (signed_mode ? MSB_MASK : {N{1'b0}});
            cnt_r <= {CW{1'b0}};
          end
        end
        SCAN: begin
          if (digit_ne_s) begin
            gt_r <= digit_gt_s;
            lt_r <= ~digit_gt_s;
            eq_r <= 1'b0;
          end else if (last_s) begin
            gt_r <= 1'b0;
            lt_r <= 1'b0;
            eq_r <= 1'b1;
          end else begin
            a_r   <= a_r << K;
            b_r   <= b_r << K;
            cnt_r <= cnt_r + ONE;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign GT   = gt_r;
  assign EQ   = eq_r;
  assign LT   = lt_r;

endmodule

// File: tb/tb_seq_comparator_nbit.sv
// Directed bench for seq_comparator_nbit: a 16-bit/K=2 instance and an
// 8-bit/K=4 signed-capable instance, checked against hand-computed vectors.
module tb_seq_comparator_nbit;

  logic        clk;
  logic        rst_n;
  logic        start16, sm16, busy16, done16, gt16, eq16, lt16;
  logic [15:0] a16, b16;
  logic        start8, sm8, busy8, done8, gt8, eq8, lt8;
  logic [7:0]  a8, b8;
  logic [2:0]  prev16, prev8;
  int          n_checks, n_pass;

  seq_comparator_nbit #(.N(16), .K(2)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
    .A(a16), .B(b16), .busy(busy16), .done(done16),
    .GT(gt16), .EQ(eq16), .LT(lt16)
  );

  seq_comparator_nbit #(.N(8), .K(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .A(a8), .B(b8), .busy(busy8), .done(done8),
    .GT(gt8), .EQ(eq8), .LT(lt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [2:0] obs_res(input int inst);
    return (inst == 1) ? {gt16, eq16, lt16} : {gt8, eq8, lt8};
  endfunction

  function automatic logic obs_busy(input int inst);
    return (inst == 1) ? busy16 : busy8;
  endfunction

  function automatic logic obs_done(input int inst);
    return (inst == 1) ? done16 : done8;
  endfunction

  // Called 1 time unit after a rising edge (cycle 0); exp_res is {GT,EQ,LT}.
  task automatic run_cmp(input string tag, input int inst, input logic [15:0] a,
                         input logic [15:0] b, input logic sm, input int exp_cyc,
                         input logic [2:0] exp_res, input int pulse_cyc);
    int done_cyc, done_cnt, busy_cnt;
    logic [2:0] res_at_done, prev;
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; res_at_done = 3'b000;
    prev = (inst == 1) ? prev16 : prev8;
    if (inst == 1) begin
      a16 = a; b16 = b; sm16 = sm; start16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; start8 = 1'b1;
    end
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(posedge clk); #1;
      start16 = 1'b0; start8 = 1'b0;
      if (cyc == 1) check({tag, "_held"}, 32'(obs_res(inst)), 32'(prev));
      if (cyc == pulse_cyc) begin
        start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h1234; sm16 = 1'b1;
      end
      if (obs_busy(inst)) busy_cnt++;
      if (obs_done(inst)) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          res_at_done = obs_res(inst);
        end
      end
    end
    check({tag, "_done_cycle"}, done_cyc, exp_cyc);
    check({tag, "_done_pulses"}, done_cnt, 32'd1);
    check({tag, "_busy_cycles"}, busy_cnt, exp_cyc - 1);
    check({tag, "_result"}, 32'(res_at_done), 32'(exp_res));
    check({tag, "_result_hold"}, 32'(obs_res(inst)), 32'(exp_res));
    if (inst == 1) prev16 = exp_res; else prev8 = exp_res;
  endtask

  initial begin
    int done_seen;
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0;
    start16 = 1'b0; sm16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
    start8 = 1'b0; sm8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    prev16 = 3'b000; prev8 = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy16", 32'(busy16), 32'd0);
    check("rst_done16", 32'(done16), 32'd0);
    check("rst_res16", 32'(obs_res(1)), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_res8", 32'(obs_res(2)), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmp("eq_1234",     1, 16'h1234, 16'h1234, 1'b0, 9, 3'b010, 0);
    run_cmp("u_8000_7fff", 1, 16'h8000, 16'h7FFF, 1'b0, 2, 3'b100, 0);
    run_cmp("s_8000_7fff", 1, 16'h8000, 16'h7FFF, 1'b1, 2, 3'b001, 0);
    run_cmp("lsb_gt",      1, 16'h1235, 16'h1234, 1'b0, 9, 3'b100, 0);
    run_cmp("lsb_lt",      1, 16'h0001, 16'h0003, 1'b0, 9, 3'b001, 0);
    run_cmp("busy_ignore", 1, 16'h0000, 16'h0000, 1'b0, 9, 3'b010, 3);

    // Reset in cycle 4 of an equal-operand compare
    a16 = 16'h1234; b16 = 16'h1234; sm16 = 1'b0; start16 = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); #1;
      start16 = 1'b0;
    end
    check("pre_rst_busy", 32'(busy16), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", 32'(busy16), 32'd0);
    check("mid_rst_done", 32'(done16), 32'd0);
    check("mid_rst_res", 32'(obs_res(1)), 32'd0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      if (done16) done_seen++;
    end
    check("mid_rst_no_done", done_seen, 32'd0);
    prev16 = 3'b000; prev8 = 3'b000;

    run_cmp("post_rst",    1, 16'h00FF, 16'h0F00, 1'b0, 4, 3'b001, 0);
    run_cmp("s_neg_neg",   1, 16'hFFFF, 16'h8000, 1'b1, 2, 3'b100, 0);
    run_cmp("n8_s_fe_03",  2, 16'h00FE, 16'h0003, 1'b1, 2, 3'b001, 0);
    run_cmp("n8_eq_5a",    2, 16'h005A, 16'h005A, 1'b0, 3, 3'b010, 0);
    run_cmp("n8_u_fe_03",  2, 16'h00FE, 16'h0003, 1'b0, 2, 3'b100, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
